// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-time SRAM loader and the processor memory
// interface: state encodings, default bus widths and active-low SRAM levels.
package mem_loader_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 19;

    // SRAM control pins are all active-low.
    localparam logic SRAM_ASSERT   = 1'b0;
    localparam logic SRAM_DEASSERT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COLLECT_LO = 3'd1,
        ST_COLLECT_HI = 3'd2,
        ST_SETUP      = 3'd3,
        ST_STROBE     = 3'd4,
        ST_HOLD       = 3'd5,
        ST_DONE       = 3'd6
    } load_state_t;

    typedef enum logic [1:0] {
        WP_IDLE   = 2'd0,
        WP_SETUP  = 2'd1,
        WP_STROBE = 2'd2,
        WP_HOLD   = 2'd3
    } wp_phase_t;

    // Little-endian byte packing: first stream byte lands in the low half.
    function automatic logic [15:0] pack_word(input logic [7:0] hi_byte,
                                              input logic [7:0] lo_byte);
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/sram_write_port.sv
// Three-clock SRAM write cycle (setup, strobe, hold) and the data tristate.
// A go pulse captures the word and byte masks; the bus is released after hold.
module sram_write_port
    import mem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_hb_mask,
    input  logic              wr_lb_mask,
    output logic              wre,
    output logic              chip_en,
    output logic              hb_mask,
    output logic              lb_mask,
    inout  wire  [DATA_W-1:0] data
);

    wp_phase_t         phase_r;
    logic [DATA_W-1:0] data_r;
    logic              drive_r;

    assign data = drive_r ? data_r : {DATA_W{1'bz}};

    // Sequence the write phases; all pin levels are registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_r <= WP_IDLE;
            data_r  <= {DATA_W{1'b0}};
            drive_r <= 1'b0;
            wre     <= SRAM_DEASSERT;
            chip_en <= SRAM_DEASSERT;
            hb_mask <= SRAM_DEASSERT;
            lb_mask <= SRAM_DEASSERT;
        end else begin
            case (phase_r)
                WP_IDLE: begin
                    if (go) begin
                        phase_r <= WP_SETUP;
                        data_r  <= wr_data;
                        drive_r <= 1'b1;
                        chip_en <= SRAM_ASSERT;
                        wre     <= SRAM_DEASSERT;
                        hb_mask <= wr_hb_mask;
                        lb_mask <= wr_lb_mask;
                    end else begin
                        phase_r <= WP_IDLE;
                    end
                end
                WP_SETUP: begin
                    phase_r <= WP_STROBE;
                    wre     <= SRAM_ASSERT;
                end
                WP_STROBE: begin
                    phase_r <= WP_HOLD;
                    wre     <= SRAM_DEASSERT;
                end
                WP_HOLD: begin
                    phase_r <= WP_IDLE;
                    drive_r <= 1'b0;
                    chip_en <= SRAM_DEASSERT;
                    hb_mask <= SRAM_DEASSERT;
                    lb_mask <= SRAM_DEASSERT;
                end
                default: begin
                    phase_r <= WP_IDLE;
                    drive_r <= 1'b0;
                    wre     <= SRAM_DEASSERT;
                    chip_en <= SRAM_DEASSERT;
                    hb_mask <= SRAM_DEASSERT;
                    lb_mask <= SRAM_DEASSERT;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Loads a byte stream into 16-bit SRAM while holding the processor off the
// bus. Bytes are packed little-endian; an odd tail writes the low byte only.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              wre,
    output logic              oute,
    output logic              hb_mask,
    output logic              lb_mask,
    output logic              chip_en,
    output logic              cpu_hold,
    output logic              done
);

    load_state_t       state_r;
    logic [CNT_W-1:0]  remaining_r;
    logic [7:0]        lo_byte_r;
    logic              accept_s;
    logic              wr_go_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              wr_hb_s;

    assign accept_s = in_valid & in_ready;
    assign oute     = SRAM_DEASSERT;

    // Hand a packed word to the write port on the edge that enters SETUP.
    always_comb begin
        wr_go_s   = 1'b0;
        wr_data_s = pack_word(8'h00, in_data);
        wr_hb_s   = SRAM_DEASSERT;
        if (accept_s && (state_r == ST_COLLECT_HI)) begin
            wr_go_s   = 1'b1;
            wr_data_s = pack_word(in_data, lo_byte_r);
            wr_hb_s   = SRAM_ASSERT;
        end else if (accept_s && (state_r == ST_COLLECT_LO) && (remaining_r == 19'd1)) begin
            wr_go_s   = 1'b1;
            wr_data_s = pack_word(8'h00, in_data);
            wr_hb_s   = SRAM_DEASSERT;
        end else begin
            wr_go_s   = 1'b0;
            wr_data_s = pack_word(8'h00, in_data);
            wr_hb_s   = SRAM_DEASSERT;
        end
    end

    // Load sequencer: byte collection, counting, addressing and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= {CNT_W{1'b0}};
            lo_byte_r   <= 8'h00;
            addr        <= {ADDR_W{1'b0}};
            in_ready    <= 1'b0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start && (byte_count == 19'd0)) begin
                        state_r  <= ST_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        in_ready <= 1'b0;
                    end else if (start) begin
                        state_r     <= ST_COLLECT_LO;
                        addr        <= start_addr;
                        remaining_r <= byte_count;
                        in_ready    <= 1'b1;
                        cpu_hold    <= 1'b1;
                        done        <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_COLLECT_LO: begin
                    if (accept_s) begin
                        lo_byte_r   <= in_data;
                        remaining_r <= remaining_r - 19'd1;
                        if (remaining_r == 19'd1) begin
                            state_r  <= ST_SETUP;
                            in_ready <= 1'b0;
                        end else begin
                            state_r <= ST_COLLECT_HI;
                        end
                    end else begin
                        state_r <= ST_COLLECT_LO;
                    end
                end
                ST_COLLECT_HI: begin
                    if (accept_s) begin
                        remaining_r <= remaining_r - 19'd1;
                        state_r     <= ST_SETUP;
                        in_ready    <= 1'b0;
                    end else begin
                        state_r <= ST_COLLECT_HI;
                    end
                end
                ST_SETUP:  state_r <= ST_STROBE;
                ST_STROBE: state_r <= ST_HOLD;
                ST_HOLD: begin
                    addr <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (remaining_r != 19'd0) begin
                        state_r  <= ST_COLLECT_LO;
                        in_ready <= 1'b1;
                    end else begin
                        state_r  <= ST_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    sram_write_port #(
        .DATA_W (DATA_W)
    ) u_write_port (
        .clock      (clock),
        .reset      (reset),
        .go         (wr_go_s),
        .wr_data    (wr_data_s),
        .wr_hb_mask (wr_hb_s),
        .wr_lb_mask (SRAM_ASSERT),
        .wre        (wre),
        .chip_en    (chip_en),
        .hb_mask    (hb_mask),
        .lb_mask    (lb_mask),
        .data       (data)
    );

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: a behavioural SRAM plus a byte-list model of the
// expected memory image, write count and done latency for each load.
module tb_mem_loader;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [18:0]   byte_count;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [AW-1:0] addr;
    wire  [DW-1:0] data;
    logic          wre, oute, hb_mask, lb_mask, chip_en, cpu_hold, done;

    logic          tb_drv = 1'b0;
    logic [15:0]   tb_val = 16'h0000;
    assign data = tb_drv ? tb_val : 16'hzzzz;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:262143];
    logic        fill_en = 1'b0;
    logic [17:0] fill_addr = 18'd0;
    logic [15:0] fill_val = 16'h0000;

    mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .byte_count(byte_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .addr(addr), .data(data), .wre(wre), .oute(oute),
        .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en),
        .cpu_hold(cpu_hold), .done(done)
    );

    always #5 clock = ~clock;

    // Behavioural SRAM: byte-masked write while chip and write enables are low.
    always @(negedge clock) begin
        if (fill_en) begin
            mem[fill_addr] <= fill_val;
        end else if (!chip_en && !wre) begin
            if (!lb_mask) mem[addr][7:0]  <= data[7:0];
            if (!hb_mask) mem[addr][15:8] <= data[15:8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // The bench drives a marker onto the bus; it reads back only if the DUT is off it.
    task automatic probe_data(input string name);
        tb_drv = 1'b1;
        tb_val = 16'hA5C3;
        #1;
        check(name, {16'h0000, data}, 32'h0000A5C3);
        tb_drv = 1'b0;
    endtask

    task automatic check_idle_pins(input string name);
        check(name, {28'h0, wre, chip_en, hb_mask, lb_mask}, 32'h0000000F);
        check("oute_high", {31'h0, oute}, 32'h1);
    endtask

    // mode 0: in_valid always high; 1: random gaps; 2: one 20-cycle stall.
    task automatic run_load(input logic [17:0] a, input int n, input int mode,
                            input int exp_cyc, input logic [31:0] fixed, input bit use_fixed);
        logic [7:0]  b [16];
        logic [15:0] pre [9];
        logic [15:0] exp_w;
        logic [17:0] wa;
        int          words, j, idx, viol, wlow, clow, stall_left;
        bit          pending, stalled;
        words = (n + 1) / 2;
        for (int i = 0; i < n; i++) begin
            if (use_fixed && i < 4) b[i] = fixed[8*i +: 8];
            else                    b[i] = 8'($urandom);
        end
        for (int k = 0; k <= words; k++) begin
            pre[k]    = 16'($urandom);
            fill_addr = a + 18'(k);
            fill_val  = pre[k];
            fill_en   = 1'b1;
            @(negedge clock);
            #1;
            fill_en = 1'b0;
        end
        start      = 1'b1;
        start_addr = a;
        byte_count = 19'(n);
        @(negedge clock);
        start = 1'b0;
        j = 0; idx = 0; pending = 1'b0; viol = 0; wlow = 0; clow = 0;
        stall_left = 0; stalled = 1'b0;
        while (!done && j < 400) begin
            if (pending) idx++;
            start = (j == 2);
            if (j == 2) begin
                start_addr = 18'($urandom);
                byte_count = 19'($urandom_range(1, 9));
            end
            if (mode == 2 && !stalled && idx == 2 && in_ready) begin
                stall_left = 20;
                stalled    = 1'b1;
            end
            if (stall_left > 0) begin
                in_valid = 1'b0;
                stall_left--;
                if (!chip_en || !wre || !cpu_hold) viol++;
            end else if (idx < n && (mode != 1 || $urandom_range(0, 2) != 0)) begin
                in_valid = 1'b1;
                in_data  = b[idx];
            end else begin
                in_valid = 1'b0;
            end
            pending = in_valid && in_ready;
            if (!oute || !cpu_hold || (in_ready && !chip_en)) viol++;
            if (!wre)     wlow++;
            if (!chip_en) clow++;
            @(negedge clock);
            j++;
        end
        if (pending) idx++;
        start    = 1'b0;
        in_valid = 1'b0;
        check("done_seen", {31'h0, done}, 32'h1);
        if (mode == 0) check("done_latency", j, exp_cyc);
        check("bytes_consumed", idx, n);
        check("write_strobes", wlow, words);
        check("chip_en_cycles", clow, 3 * words);
        check("per_cycle_rules", viol, 0);
        if (mode == 2) check("stall_taken", {31'h0, stalled}, 32'h1);
        check("cpu_hold_after", {31'h0, cpu_hold}, 32'h0);
        check("in_ready_after", {31'h0, in_ready}, 32'h0);
        check_idle_pins("pins_after_load");
        for (int k = 0; k < words; k++) begin
            wa = a + 18'(k);
            if (2*k + 1 < n) exp_w = {b[2*k+1], b[2*k]};
            else             exp_w = {pre[k][15:8], b[2*k]};
            check("mem_word", {16'h0000, mem[wa]}, {16'h0000, exp_w});
        end
        wa = a + 18'(words);
        check("mem_past_end", {16'h0000, mem[wa]}, {16'h0000, pre[words]});
    endtask

    typedef struct {
        logic [17:0] a;
        int          n;
        int          mode;
        int          exp_cyc;
        logic [31:0] fixed;
        bit          use_fixed;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          j, n;
        logic [17:0] ra;

        tbl[0] = '{18'd0,      4,  0, 10, 32'h100b2004, 1'b1};
        tbl[1] = '{18'd5,      3,  0, 9,  32'h00CCBBAA, 1'b1};
        tbl[2] = '{18'd262143, 4,  0, 10, 32'h0,        1'b0};
        tbl[3] = '{18'd777,    0,  0, 0,  32'h0,        1'b0};
        tbl[4] = '{18'd4000,   7,  1, 0,  32'h0,        1'b0};
        tbl[5] = '{18'd1000,   6,  2, 0,  32'h0,        1'b0};
        tbl[6] = '{18'd300,    1,  0, 4,  32'h0,        1'b0};
        tbl[7] = '{18'd50000,  10, 0, 25, 32'h0,        1'b0};

        reset = 1'b1; start = 1'b0; start_addr = 18'd0; byte_count = 19'd0;
        in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_addr", {14'h0, addr}, 32'h0);
        check("rst_flags", {29'h0, in_ready, cpu_hold, done}, 32'h0);
        check_idle_pins("rst_pins");
        probe_data("rst_data_z");
        reset = 1'b0;
        @(negedge clock);

        // Reset while the first write is strobing abandons it.
        start = 1'b1; start_addr = 18'd100; byte_count = 19'd4;
        @(negedge clock);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        j = 0;
        while (wre && j < 20) begin
            @(negedge clock);
            j++;
        end
        check("reach_strobe", {31'h0, wre}, 32'h0);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clock);
        check_idle_pins("mid_write_reset_pins");
        check("mid_write_reset_flags", {29'h0, in_ready, cpu_hold, done}, 32'h0);
        check("mid_write_reset_addr", {14'h0, addr}, 32'h0);
        probe_data("mid_write_reset_data_z");
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_load(tbl[i].a, tbl[i].n, tbl[i].mode, tbl[i].exp_cyc,
                     tbl[i].fixed, tbl[i].use_fixed);
        end
        probe_data("done_data_z");

        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(0, 12);
            ra = 18'($urandom);
            run_load(ra, n, r % 2, 5 * (n / 2) + 4 * (n % 2), 32'h0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
